divisor_4bit: RTL and testbench
===============================

# divisor_4bit

Sequential restoring divider for 4-bit unsigned operands in the ALU project, the inverse arithmetic counterpart of `sumador_4bit`. It accepts a dividend/divisor pair on a start pulse and produces quotient and remainder after four iterations, one per clock. Each iteration uses a single trial subtraction through a ripple subtractor built from `sumador_1bit` cells. A start/busy/done handshake lets the ALU sequencer issue back-to-back divisions.

## Interface
- `N`, 4: operand width; only 4 is verified.
- `clk`  in  1  rising-edge clock, the single clock of the block.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  request a division; sampled only when not busy.
- `A`  in  4  dividend, latched on an accepted start.
- `B`  in  4  divisor, latched on an accepted start.
- `busy`  out  1  high while iterating.
- `done`  out  1  one-cycle pulse; `Q`, `R` and `div0` are valid.
- `Q`  out  4  quotient.
- `R`  out  4  remainder.
- `div0`  out  1  set when the last accepted divisor was 0.

## Operation
- States and transitions:
  - IDLE → CALC on `start` with `B`≠0.
  - IDLE → FIN on `start` with `B`=0.
  - CALC → FIN when the iteration counter reaches 0.
  - FIN → IDLE when `start`=0.
  - FIN → CALC or FIN (same rule as IDLE) when `start`=1.
- On accept:
  - Latch `B` into the divisor register.
  - Load the quotient shift register with `A`, the partial remainder with 0, and the counter with 3.
  - Clear `div0`.
- Each CALC cycle:
  - Shift the {remainder, quotient} pair left by one. `msb` is the bit shifted out of the remainder.
  - Compute the trial `low − B`, where `low` is the new 4-bit remainder, using the subtractor: `B` inverted, Ci=1, borrow = NOT Cout.
  - Accept the trial if `msb`=1 or borrow=0. On accept, the remainder becomes the trial difference (its low 4 bits are exact) and the quotient LSB becomes 1.
  - Otherwise keep the remainder and set the quotient LSB to 0.
  - Decrement the counter.
- Divide by zero: `Q`=4'hF, `R`=`A`, `div0`=1, with no iterations.
- `Q` and `R` hold their values from FIN until the next accepted start. They are not cleared on return to IDLE.
- `start` while `busy` is ignored, and the operands are not re-latched.
- `A` and `B` may change freely after the accept cycle.

## Timing
- Reset values: state IDLE, `busy`=0, `done`=0, `Q`=0, `R`=0, `div0`=0, counter 0.
- Normal division, start accepted at edge k:
  - `busy` is high in the cycles after edges k through k+3.
  - Iterations occur at edges k+1 through k+4.
  - `done` is high in the cycle after edge k+4.
  - Latency is 5 cycles from start to `done`.
- Divide by zero, start accepted at edge k: `done` is high in the cycle after edge k and `busy` never rises.
- `done` is never high for two consecutive cycles unless a new start is accepted during FIN.
  - A start held high through FIN is accepted there.
  - The resulting `done` then follows the same latency rules.
- `rst` during CALC aborts immediately:
  - All outputs return to their reset values at that edge.
  - No `done` is produced.
- `rst` has priority over `start` in the same cycle.

## Structure
- Shared package `alu_pkg`:
  - state encoding constants `S_IDLE`, `S_CALC`, `S_FIN`
  - operand width constant
  - counter width (2)
- Sub-module `restador_4bit`: four `sumador_1bit` instances in a ripple chain, computing `A − B` with borrow output. It is reusable by the ALU subtract path.
- Top level contains the FSM, counter, and the remainder, quotient and divisor registers.

## Test plan
- A=13, B=3 → after 5 cycles `done`=1, Q=4, R=1, `div0`=0. `busy` is high for exactly 4 cycles.
- A=15, B=1 → Q=15, R=0. A=2, B=9 → Q=0, R=2.
- A=7, B=0 → `done` one cycle after start, Q=4'hF, R=7, `div0`=1, `busy` never high.
- A=14, B=5, with `start` re-pulsed with A=3, B=1 during `busy` → the second start is ignored and the result is Q=2, R=4.
- `rst` asserted 2 cycles into CALC for A=9, B=2 → outputs zero next cycle and no `done`. A following start with A=9, B=2 gives Q=4, R=1.
- Exhaustive sweep of all 256 (A, B) pairs with back-to-back starts held through FIN:
  - Each result matches the model Q=A/B, R=A%B for B≠0, and the divide-by-zero rule otherwise.
  - There is exactly one `done` per accepted start.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared ALU definitions: operand width, divider counter width and FSM state encoding.
package alu_pkg;

  localparam int OPW   = 4;
  localparam int CNT_W = 2;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIN  = 2'd2
  } state_t;

endpackage

// File: rtl/restador_4bit.sv
// Ripple subtractor a - b built from full-adder cells (b inverted, carry-in 1).
// Combinational; borrow is the inverted final carry.
module restador_4bit #(
  parameter int W = 4
) (
  input  logic [W-1:0] i_a,
  input  logic [W-1:0] i_b,
  output logic [W-1:0] o_diff,
  output logic         o_borrow
);

  logic [W:0] w_c;

  assign w_c[0] = 1'b1;

  for (genvar i = 0; i < W; i++) begin : g_cell
    sumador_1bit u_fa (
      .i_a  (i_a[i]),
      .i_b  (~i_b[i]),
      .i_ci (w_c[i]),
      .o_s  (o_diff[i]),
      .o_co (w_c[i+1])
    );
  end

  assign o_borrow = ~w_c[W];

endmodule

// File: rtl/sumador_1bit.sv
// One-bit full adder cell, building block for the ripple adder/subtractor chains.
module sumador_1bit (
  input  logic i_a,
  input  logic i_b,
  input  logic i_ci,
  output logic o_s,
  output logic o_co
);

  logic w_p;

  assign w_p  = i_a ^ i_b;
  assign o_s  = w_p ^ i_ci;
  assign o_co = (i_a & i_b) | (i_ci & w_p);

endmodule

// File: rtl/divisor_4bit.sv
// Restoring divider, one quotient bit per clock: done 5 cycles after start (1 on divide-by-zero).
// start is ignored while busy; a start held through FIN is accepted immediately.
module divisor_4bit
  import alu_pkg::*;
#(
  parameter int N = OPW
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [N-1:0] A,
  input  logic [N-1:0] B,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] Q,
  output logic [N-1:0] R,
  output logic         div0
);

  state_t           r_state, w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [N-1:0]     r_rem, r_quo, r_div;
  logic             r_div0;

  logic             w_accept, w_msb, w_borrow, w_take;
  logic [N-1:0]     w_low, w_diff;

  // Left shift of {remainder, quotient}: the remainder MSB falls out as w_msb.
  assign w_msb = r_rem[N-1];
  assign w_low = {r_rem[N-2:0], r_quo[N-1]};

  restador_4bit #(.W(N)) u_sub (
    .i_a      (w_low),
    .i_b      (r_div),
    .o_diff   (w_diff),
    .o_borrow (w_borrow)
  );

  // A shifted-out 1 means the 5-bit value already exceeds the divisor.
  assign w_take = w_msb | ~w_borrow;

  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    busy        = 1'b0;
    done        = 1'b0;
    case (r_state)
      S_IDLE, S_FIN: begin
        done = (r_state == S_FIN);
        if (start) begin
          w_accept    = 1'b1;
          w_state_nxt = (B == '0) ? S_FIN : S_CALC;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_CALC: begin
        busy = 1'b1;
        if (r_cnt == '0) w_state_nxt = S_FIN;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_rem   <= '0;
      r_quo   <= '0;
      r_div   <= '0;
      r_div0  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_accept) begin
        r_div  <= B;
        r_div0 <= (B == '0);
        if (B == '0) begin
          r_quo <= '1;
          r_rem <= A;
          r_cnt <= '0;
        end else begin
          r_quo <= A;
          r_rem <= '0;
          r_cnt <= CNT_W'(N - 1);
        end
      end else if (r_state == S_CALC) begin
        r_rem <= w_take ? w_diff : w_low;
        r_quo <= {r_quo[N-2:0], w_take};
        if (r_cnt != '0) r_cnt <= r_cnt - 1'b1;
      end
    end
  end

  assign Q    = r_quo;
  assign R    = r_rem;
  assign div0 = r_div0;

endmodule

// File: tb/tb_divisor_4bit.sv
// Self-checking bench for divisor_4bit against an arithmetic reference (A/B, A%B).
module tb_divisor_4bit;

  logic       clk = 1'b0;
  logic       rst, start, busy, done, div0;
  logic [3:0] A, B, Q, R;

  int n_chk  = 0;
  int n_fail = 0;

  divisor_4bit dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .A     (A),
    .B     (B),
    .busy  (busy),
    .done  (done),
    .Q     (Q),
    .R     (R),
    .div0  (div0)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [3:0] ref_q(input logic [3:0] a, input logic [3:0] b);
    return (b == 0) ? 4'hF : 4'(a / b);
  endfunction

  function automatic logic [3:0] ref_r(input logic [3:0] a, input logic [3:0] b);
    return (b == 0) ? a : 4'(a % b);
  endfunction

  // One isolated division: checks latency, busy length, results and hold after done.
  task automatic run_div(input string tag, input logic [3:0] a, input logic [3:0] b);
    int busy_n = 0;
    int lat    = 0;
    start = 1'b1; A = a; B = b;
    tick;
    start = 1'b0; A = $urandom; B = $urandom;
    for (int i = 1; i <= 8; i++) begin
      if (busy) busy_n++;
      if (done) begin
        lat = i;
        break;
      end
      tick;
    end
    chk({tag, "_lat"},  lat,    (b == 0) ? 1 : 5);
    chk({tag, "_busy"}, busy_n, (b == 0) ? 0 : 4);
    chk({tag, "_q"},    Q,      ref_q(a, b));
    chk({tag, "_r"},    R,      ref_r(a, b));
    chk({tag, "_div0"}, div0,   (b == 0));
    tick;
    chk({tag, "_done_pulse"}, done, 0);
    chk({tag, "_q_hold"},     Q,    ref_q(a, b));
    chk({tag, "_r_hold"},     R,    ref_r(a, b));
  endtask

  initial begin
    logic [7:0] order[256];
    logic [7:0] pending, tmp;
    int         nextidx, ndone, since, cyc, extra, lat, j;

    rst = 1'b1; start = 1'b0; A = '0; B = '0;
    tick; tick;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_q",    Q,    0);
    chk("rst_r",    R,    0);
    chk("rst_div0", div0, 0);
    start = 1'b1; A = 4'd13; B = 4'd3;
    tick;
    chk("rst_prio_busy", busy, 0);
    rst = 1'b0; start = 1'b0;
    tick;

    run_div("d13_3", 4'd13, 4'd3);
    run_div("d15_1", 4'd15, 4'd1);
    run_div("d2_9",  4'd2,  4'd9);
    run_div("d7_0",  4'd7,  4'd0);

    // Re-pulsed start while busy must not relatch operands.
    start = 1'b1; A = 4'd14; B = 4'd5;
    tick;
    lat = 0;
    for (int i = 1; i <= 8; i++) begin
      start = (i == 2); A = 4'd3; B = 4'd1;
      if (done) begin
        lat = i;
        break;
      end
      tick;
    end
    start = 1'b0;
    chk("busy_ign_lat", lat, 5);
    chk("busy_ign_q",   Q,   2);
    chk("busy_ign_r",   R,   4);
    tick;
    chk("busy_ign_nodone", done, 0);

    // Reset two cycles into CALC aborts without a done.
    start = 1'b1; A = 4'd9; B = 4'd2;
    tick;
    start = 1'b0;
    tick;
    rst = 1'b1;
    tick;
    rst = 1'b0;
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    chk("abort_q",    Q,    0);
    chk("abort_r",    R,    0);
    chk("abort_div0", div0, 0);
    extra = 0;
    for (int i = 0; i < 6; i++) begin
      if (done) extra++;
      tick;
    end
    chk("abort_no_done", extra, 0);
    run_div("d9_2_after", 4'd9, 4'd2);

    for (int i = 0; i < 6; i++) run_div("rand", 4'($urandom), 4'($urandom));

    // Exhaustive sweep in shuffled order with start held through FIN.
    for (int i = 0; i < 256; i++) order[i] = 8'(i);
    for (int i = 255; i > 0; i--) begin
      j = $urandom_range(i, 0);
      tmp = order[i]; order[i] = order[j]; order[j] = tmp;
    end
    start = 1'b1; A = order[0][7:4]; B = order[0][3:0];
    tick;
    pending = order[0];
    nextidx = 1;
    A = order[1][7:4]; B = order[1][3:0];
    since = 1; ndone = 0; cyc = 0;
    while (ndone < 256 && cyc < 3000) begin
      cyc++;
      if (done) begin
        chk("sweep_lat",  since, (pending[3:0] == 0) ? 1 : 5);
        chk("sweep_q",    Q,     ref_q(pending[7:4], pending[3:0]));
        chk("sweep_r",    R,     ref_r(pending[7:4], pending[3:0]));
        chk("sweep_div0", div0,  (pending[3:0] == 0));
        ndone++;
        if (nextidx < 256) begin
          pending = order[nextidx];
          nextidx++;
        end else begin
          start = 1'b0;
        end
        tick;
        since = 1;
        if (nextidx < 256) begin
          A = order[nextidx][7:4]; B = order[nextidx][3:0];
        end else begin
          start = 1'b0;
        end
      end else begin
        tick;
        since++;
      end
    end
    chk("sweep_done_count", ndone, 256);
    extra = 0;
    for (int i = 0; i < 8; i++) begin
      if (done) extra++;
      tick;
    end
    chk("sweep_no_extra_done", extra, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
